// File: rtl/rr_packet_arbiter_pkg.sv
// Shared scheduler definitions: FSM state encoding and
// source-index width helper used by the arbiter and rr_pick.
package rr_packet_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Width of a requester index; never less than one bit.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_packet_arbiter_pick.sv
// rr_pick: round-robin picker. Finds the first set bit of req
// starting at ptr and wrapping. Ports: req, ptr in; any, idx out.
module rr_pick
    import rr_packet_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int SRC_W = src_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] ptr,
    output logic             any,
    output logic [SRC_W-1:0] idx
);

    logic [N-1:0] rot;
    logic         found;
    int           off;

    // Explicit compare keeps non-power-of-two N correct.
    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    always_comb begin
        rot   = '0;
        found = 1'b0;
        off   = 0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req[wrap(int'(ptr) + k)];
        end
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        any = |rot;
        idx = SRC_W'(wrap(int'(ptr) + off));
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: per-packet round-robin mux of N_INPUTS valid/ready
// streams onto one registered output. Ports: clk, rst; in_valid,
// in_data, in_last, in_ready; cfg_mask; out_valid, out_data, out_last,
// out_src, out_ready; busy.
module rr_packet_arbiter
    import rr_packet_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_INPUTS   = 4,
    parameter int SRC_W      = src_w(N_INPUTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_INPUTS-1:0]            in_valid,
    input  logic [DATA_WIDTH*N_INPUTS-1:0] in_data,
    input  logic [N_INPUTS-1:0]            in_last,
    output logic [N_INPUTS-1:0]            in_ready,
    input  logic [N_INPUTS-1:0]            cfg_mask,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic [SRC_W-1:0]               out_src,
    input  logic                           out_ready,
    output logic                           busy
);

    state_t state, state_n;

    logic [SRC_W-1:0] ptr, ptr_n;
    logic [SRC_W-1:0] owner, owner_n;
    logic [SRC_W-1:0] g;
    logic [SRC_W-1:0] pick_idx;
    logic             pick_any;
    logic             gv;
    logic             slot_free;
    logic             xfer;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

    assign slot_free = !out_valid || out_ready;

    rr_pick #(
        .N     (N_INPUTS),
        .SRC_W (SRC_W)
    ) u_pick (
        .req (in_valid & ~cfg_mask),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Locked packets ignore cfg_mask so they are never truncated.
    always_comb begin
        g  = '0;
        gv = 1'b0;
        unique case (state)
            ST_IDLE: begin
                g  = pick_idx;
                gv = pick_any;
            end
            ST_LOCKED: begin
                g  = owner;
                gv = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            in_ready[i] = !rst && gv && slot_free
                        && (g == SRC_W'(i));
        end
    end

    assign xfer     = |(in_valid & in_ready);
    assign sel_data = in_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_last = in_last[g];

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        if (xfer) begin
            if (sel_last) begin
                state_n = ST_IDLE;
                ptr_n   = (g == SRC_W'(N_INPUTS - 1))
                        ? '0 : g + SRC_W'(1);
            end else begin
                state_n = ST_LOCKED;
                owner_n = g;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
        end
    end

    // Drain and reload in one cycle gives one beat per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_src   <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = (state == ST_LOCKED);

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed testbench for rr_packet_arbiter (N_INPUTS=4, DATA_WIDTH=16).
// Drives after each rising edge, samples 1 time unit later.
module tb_rr_packet_arbiter;

    localparam int DW = 16;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_valid;
    logic [DW*N-1:0] in_data;
    logic [N-1:0]  in_last;
    logic [N-1:0]  in_ready;
    logic [N-1:0]  cfg_mask;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    out_src;
    logic          out_ready;
    logic          busy;

    logic [DW-1:0] dat [N];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = dat[i];
    end

    rr_packet_arbiter #(
        .DATA_WIDTH (DW),
        .N_INPUTS   (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .cfg_mask  (cfg_mask),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int src,
                        input logic [15:0] d, input logic l,
                        input logic b);
        tick();
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " src"}, 32'(out_src), 32'(src));
        chk({tag, " data"}, 32'(out_data), 32'(d));
        chk({tag, " last"}, 32'(out_last), 32'(l));
        chk({tag, " busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        cfg_mask  = '0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        for (int i = 0; i < N; i++) dat[i] = 16'h00A0 + 16'(i);
        tick();
        tick();
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_data", 32'(out_data), 0);
        chk("rst out_last", 32'(out_last), 0);
        chk("rst out_src", 32'(out_src), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("idle in_ready", 32'(in_ready), 32'b0001);

        // single-beat round robin: 0,1,2,3,0,1,2,3,0,1 -> ptr=2
        for (int k = 0; k < 10; k++) begin
            beat("rr", k % 4, 16'h00A0 + 16'(k % 4), 1'b1, 1'b0);
        end

        // 3-beat packet from requester 2 with others waiting
        for (int i = 0; i < N; i++) dat[i] = 16'h00C0 + 16'(i);
        dat[2]  = 16'h00B0;
        in_last = 4'b1011;
        beat("pk0", 2, 16'h00B0, 1'b0, 1'b1);
        dat[2] = 16'h00B1;
        beat("pk1", 2, 16'h00B1, 1'b0, 1'b1);
        dat[2]  = 16'h00B2;
        in_last = 4'b1111;
        beat("pk2", 2, 16'h00B2, 1'b1, 1'b0);
        in_valid = 4'b1011;
        beat("next3", 3, 16'h00C3, 1'b1, 1'b0);
        beat("next0", 0, 16'h00C0, 1'b1, 1'b0);

        // backpressure mid-packet on requester 1 (ptr=1)
        in_valid = 4'b0010;
        dat[1]   = 16'h00D0;
        in_last  = 4'b0000;
        beat("bp0", 1, 16'h00D0, 1'b0, 1'b1);
        out_ready = 1'b0;
        dat[1]    = 16'h00D1;
        #1;
        chk("bp in_ready", 32'(in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            beat("bp hold", 1, 16'h00D0, 1'b0, 1'b1);
            chk("bp hold in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'b0010);
        beat("bp1", 1, 16'h00D1, 1'b0, 1'b1);
        dat[1]  = 16'h00D2;
        in_last = 4'b0010;
        beat("bp2", 1, 16'h00D2, 1'b1, 1'b0);
        in_valid = 4'b0000;
        tick();
        chk("bp drain", 32'(out_valid), 0);

        // owner stalls with requester 1 waiting (ptr=2)
        in_valid = 4'b0100;
        in_last  = 4'b0000;
        dat[2]   = 16'h00E0;
        beat("st0", 2, 16'h00E0, 1'b0, 1'b1);
        in_valid = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("st gap valid", 32'(out_valid), 0);
            chk("st gap busy", 32'(busy), 1);
            chk("st gap in_ready", 32'(in_ready), 32'b0100);
        end
        in_valid = 4'b0110;
        in_last  = 4'b0110;
        dat[2]   = 16'h00E1;
        dat[1]   = 16'h00E5;
        beat("st1", 2, 16'h00E1, 1'b1, 1'b0);
        in_valid = 4'b0010;
        beat("st after", 1, 16'h00E5, 1'b1, 1'b0);

        // mask requester 1 with all valid (ptr=2)
        for (int i = 0; i < N; i++) dat[i] = 16'h00F0 + 16'(i);
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        cfg_mask = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mask src", 32'(out_src), (k % 3 == 0) ? 2 : (k % 3 == 1) ? 3 : 0);
            chk("mask valid", 32'(out_valid), 1);
        end

        // masking the owner does not truncate its packet (ptr=1)
        cfg_mask = 4'b0000;
        in_valid = 4'b0100;
        in_last  = 4'b1011;
        dat[2]   = 16'h0F00;
        beat("ml0", 2, 16'h0F00, 1'b0, 1'b1);
        cfg_mask = 4'b0100;
        in_valid = 4'b1111;
        dat[2]   = 16'h0F01;
        beat("ml1", 2, 16'h0F01, 1'b0, 1'b1);
        dat[2]  = 16'h0F02;
        in_last = 4'b1111;
        beat("ml2", 2, 16'h0F02, 1'b1, 1'b0);

        // reset during a locked packet from requester 3 (ptr=3)
        cfg_mask = 4'b0000;
        in_valid = 4'b1000;
        in_last  = 4'b0000;
        dat[3]   = 16'h0123;
        beat("rl0", 3, 16'h0123, 1'b0, 1'b1);
        rst      = 1'b1;
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        #1;
        chk("rl in_ready", 32'(in_ready), 0);
        tick();
        chk("rl out_valid", 32'(out_valid), 0);
        chk("rl busy", 32'(busy), 0);
        chk("rl out_src", 32'(out_src), 0);
        rst = 1'b0;
        beat("rl first", 0, 16'h00F0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
